// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module : mips_mem_pkg
// Brief  : Access-size codes, LSU state encoding and lane helper functions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] be_table(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << off;
            SIZE_H:  be = off[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~off[0];
            SIZE_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Narrow stores are copied onto every lane so the byte enables alone pick the target.
    function automatic logic [31:0] wdata_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_B:  d = {4{wdata[7:0]}};
            SIZE_H:  d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_lsu_bridge_if.sv
// ============================================================================
// Module : mips_lsu_bridge_if
// Brief  : Handshaked data-memory bus between the LSU bridge and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_lsu_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mips_load_align.sv
// ============================================================================
// Module : mips_load_align
// Brief  : Selects the addressed byte/half lane of a bus word and extends it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_mem_rdata >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        o_data = 32'h0;
        case (i_size)
            SIZE_B:  o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SIZE_H:  o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
            SIZE_W:  o_data = i_mem_rdata;
            default: o_data = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_lsu_bridge.sv
// ============================================================================
// Module : mips_lsu_bridge
// Brief  : Load/store unit bridging the single-cycle datapath to a slow bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_lsu_bridge
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [1:0]               size,
    input  logic                     sign_ext,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     stall,
    output logic                     err,
    mips_lsu_bridge_if.master        bus
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;
    logic [1:0]       r_size;
    logic [1:0]       r_off;
    logic             r_sign_ext;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_rdata;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_legal;
    logic             w_accept;
    logic             w_capture;
    logic             w_abort;
    logic             w_expired;
    logic             w_busy_nxt;
    logic [31:0]      w_align_data;

    mips_load_align u_align (
        .i_mem_rdata (bus.mem_rdata),
        .i_off       (r_off),
        .i_size      (r_size),
        .i_sign_ext  (r_sign_ext),
        .o_data      (w_align_data)
    );

    assign w_legal   = is_legal(size, addr[1:0]);
    assign w_accept  = (r_state == ST_IDLE) && req && w_legal;
    assign w_expired = (r_cnt == C_TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        stall       = 1'b0;
        err         = 1'b0;
        rdata       = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_legal) begin
                        stall       = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        // A reset already pending this cycle suppresses the error report.
                        err = rst;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus.mem_gnt) begin
                    if (r_mem_we) begin
                        w_state_nxt = ST_DONE;
                    end else if (bus.mem_rvalid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rdata       = r_rdata;
                err         = r_timeout;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_sign_ext  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt == ST_REQ);
            if (w_accept) begin
                r_size      <= size;
                r_off       <= addr[1:0];
                r_sign_ext  <= sign_ext;
                r_mem_we    <= we;
                r_mem_addr  <= {addr[31:2], 2'b00};
                r_mem_be    <= be_table(size, addr[1:0]);
                r_mem_wdata <= wdata_lanes(size, wdata);
                r_rdata     <= 32'h0;
                r_timeout   <= 1'b0;
            end
            if (w_capture) begin
                r_rdata <= w_align_data;
            end
            if (w_abort) begin
                r_rdata   <= 32'h0;
                r_timeout <= 1'b1;
            end
            // Counts cycles already spent in REQ/WAIT for the current access.
            if (((r_state == ST_REQ) || (r_state == ST_WAIT)) && w_busy_nxt) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mips_lsu_bridge.sv
// ============================================================================
// Module : tb_mips_lsu_bridge
// Brief  : Directed vector bench for mips_lsu_bridge with a reactive memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_lsu_bridge;
    import mips_mem_pkg::*;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          gnt_dly;
        int          rv_dly;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        logic        exp_err;
        logic        exp_bus;
    } vec_t;

    localparam int NVEC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int total  = 0;
    int passed = 0;

    vec_t vecs [NVEC];

    mips_lsu_bridge_if bus ();

    mips_lsu_bridge #(.TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    endtask

    // Drives one access from a negedge and answers the bus until stall drops.
    task automatic run_access(input int idx, input vec_t v);
        int          req_cyc = 0;
        int          wait_cyc = 0;
        int          stalls = 0;
        bit          granted = 0;
        bit          done = 0;
        bit          saw_req = 0;
        logic [31:0] got_addr = 32'h0;
        logic [31:0] got_wdata = 32'h0;
        logic [3:0]  got_be = 4'h0;
        logic        got_we = 1'b0;
        logic [31:0] got_rdata = 32'h0;
        logic        got_err = 1'b0;
        logic        got_mreq = 1'b0;
        @(negedge clk);
        req = 1'b1; we = v.we; size = v.size; sign_ext = v.sx;
        addr = v.addr; wdata = v.wdata; bus.mem_rdata = v.word;
        for (int n = 0; n < 64 && !done; n++) begin
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.mem_req && !granted) begin
                saw_req   = 1;
                got_addr  = bus.mem_addr;
                got_be    = bus.mem_be;
                got_wdata = bus.mem_wdata;
                got_we    = bus.mem_we;
                if (req_cyc == v.gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    granted = 1;
                    if (!v.we && v.rv_dly == 0) bus.mem_rvalid = 1'b1;
                end
                req_cyc++;
            end else if (granted && !v.we) begin
                wait_cyc++;
                if (wait_cyc == v.rv_dly) bus.mem_rvalid = 1'b1;
            end
            #1;
            if (stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                done      = 1;
                got_rdata = rdata;
                got_err   = err;
                got_mreq  = bus.mem_req;
            end
        end
        chk($sformatf("v%0d completion", idx), {31'b0, done}, 32'd1);
        chk($sformatf("v%0d stall cycles", idx), stalls, v.exp_stalls);
        chk($sformatf("v%0d err at completion", idx), {31'b0, got_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d rdata", idx), got_rdata, v.exp_rdata);
        chk($sformatf("v%0d mem_req at completion", idx), {31'b0, got_mreq}, 32'd0);
        chk($sformatf("v%0d bus used", idx), {31'b0, saw_req}, {31'b0, v.exp_bus});
        if (v.exp_bus) begin
            chk($sformatf("v%0d mem_addr", idx), got_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d mem_be", idx), {28'b0, got_be}, {28'b0, v.be});
            chk($sformatf("v%0d mem_we", idx), {31'b0, got_we}, {31'b0, v.we});
            if (v.we) chk($sformatf("v%0d mem_wdata", idx), got_wdata, v.exp_wdata);
        end
        @(negedge clk);
        req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        chk($sformatf("v%0d err after", idx), {31'b0, err}, 32'd0);
        chk($sformatf("v%0d stall after", idx), {31'b0, stall}, 32'd0);
    endtask

    initial begin
        //            we    size    sx    addr        wdata        word          g   r   be       exp_wdata     exp_rdata    st  err   bus
        vecs[0]  = '{1'b0, SIZE_B, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 0,  0,  4'b1000, 32'h0,        32'hFFFFFF80, 2,  1'b0, 1'b1};
        vecs[1]  = '{1'b0, SIZE_B, 1'b0, 32'h103, 32'h0,        32'h80FF1234, 0,  0,  4'b1000, 32'h0,        32'h00000080, 2,  1'b0, 1'b1};
        vecs[2]  = '{1'b0, SIZE_H, 1'b0, 32'h102, 32'h0,        32'hBEEF0000, 1,  0,  4'b1100, 32'h0,        32'h0000BEEF, 3,  1'b0, 1'b1};
        vecs[3]  = '{1'b0, SIZE_H, 1'b1, 32'h100, 32'h0,        32'h12348001, 0,  1,  4'b0011, 32'h0,        32'hFFFF8001, 3,  1'b0, 1'b1};
        vecs[4]  = '{1'b0, SIZE_W, 1'b0, 32'h10C, 32'h0,        32'hDEADBEEF, 2,  2,  4'b1111, 32'h0,        32'hDEADBEEF, 6,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, SIZE_B, 1'b1, 32'h101, 32'h0,        32'h123456F0, 0,  0,  4'b0010, 32'h0,        32'h00000056, 2,  1'b0, 1'b1};
        vecs[6]  = '{1'b1, SIZE_B, 1'b0, 32'h201, 32'h000000AB, 32'h0,        0,  0,  4'b0010, 32'hABABABAB, 32'h0,        2,  1'b0, 1'b1};
        vecs[7]  = '{1'b1, SIZE_H, 1'b0, 32'h302, 32'h1234CAFE, 32'h0,        3,  0,  4'b1100, 32'hCAFECAFE, 32'h0,        5,  1'b0, 1'b1};
        vecs[8]  = '{1'b1, SIZE_W, 1'b0, 32'h404, 32'h01234567, 32'h0,        0,  0,  4'b1111, 32'h01234567, 32'h0,        2,  1'b0, 1'b1};
        vecs[9]  = '{1'b1, SIZE_B, 1'b0, 32'h007, 32'hFFFFFF5A, 32'h0,        1,  0,  4'b1000, 32'h5A5A5A5A, 32'h0,        3,  1'b0, 1'b1};
        vecs[10] = '{1'b0, SIZE_W, 1'b0, 32'h102, 32'h0,        32'h11111111, 0,  0,  4'b0000, 32'h0,        32'h0,        0,  1'b1, 1'b0};
        vecs[11] = '{1'b0, SIZE_H, 1'b1, 32'h101, 32'h0,        32'h11111111, 0,  0,  4'b0000, 32'h0,        32'h0,        0,  1'b1, 1'b0};
        vecs[12] = '{1'b0, SIZE_R, 1'b0, 32'h100, 32'h0,        32'h11111111, 0,  0,  4'b0000, 32'h0,        32'h0,        0,  1'b1, 1'b0};
        vecs[13] = '{1'b1, SIZE_H, 1'b0, 32'h203, 32'h0000BEEF, 32'h0,        0,  0,  4'b0000, 32'h0,        32'h0,        0,  1'b1, 1'b0};
        vecs[14] = '{1'b0, SIZE_W, 1'b0, 32'h500, 32'h0,        32'hCAFEF00D, 99, 0,  4'b1111, 32'h0,        32'h0,        17, 1'b1, 1'b1};
        vecs[15] = '{1'b0, SIZE_B, 1'b0, 32'h502, 32'h0,        32'hCAFEF00D, 0,  99, 4'b0100, 32'h0,        32'h0,        17, 1'b1, 1'b1};

        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("reset mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("reset mem_be", {28'b0, bus.mem_be}, 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'h0);
        chk("reset mem_wdata", bus.mem_wdata, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset err", {31'b0, err}, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_access(i, vecs[i]);

        // Reset while waiting for load data; the late rvalid must be dropped.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = SIZE_W; sign_ext = 1'b0; addr = 32'h600;
        bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1 chk("rstwait mem_req in REQ", {31'b0, bus.mem_req}, 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1 chk("rstwait stall in WAIT", {31'b0, stall}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; req = 1'b0; bus.mem_rvalid = 1'b1;
        #1;
        chk("rstwait stall", {31'b0, stall}, 32'd0);
        chk("rstwait err", {31'b0, err}, 32'd0);
        chk("rstwait rdata", rdata, 32'h0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("rstwait stall next", {31'b0, stall}, 32'd0);
        chk("rstwait err next", {31'b0, err}, 32'd0);
        chk("rstwait rdata next", rdata, 32'h0);
        chk("rstwait mem_req next", {31'b0, bus.mem_req}, 32'd0);

        // Reset during REQ drops mem_req on the same edge.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SIZE_W; addr = 32'h700; wdata = 32'h55AA55AA;
        @(negedge clk);
        #1 chk("rstreq mem_req in REQ", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstreq mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rstreq err", {31'b0, err}, 32'd0);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        #1 chk("rstreq stall idle", {31'b0, stall}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
